// File: rtl/module_result_emitter.sv
// Binary-to-BCD result emitter: double-dabble conversion, then LSD-first digit handshake.
// Optional build macro LEADING_ZERO_BLANK_EN: blank (4'hF) digits above the leading nonzero one.
module module_result_emitter #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] valor,
    input  logic             start,
    output logic             busy,
    output logic [3:0]       dato,
    output logic             dat_ready,
    input  logic             dat_ack,
    output logic             done,
    output logic             overflow
);

    localparam int MAX_VAL = 10**DIGITS - 1;
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, SEND} state_t;

    state_t          state;
    state_t          state_nx;
    logic [WIDTH-1:0] bin;
    logic [BW-1:0]   bcd;
    logic [BW-1:0]   bcd_adj;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic            last_shift;
    logic            last_digit;
    logic            xfer;

    assign last_shift = (cnt == CW'(1));
    assign last_digit = (idx == IW'(DIGITS - 1));
    assign xfer       = (state == SEND) && dat_ack;
    assign busy       = (state != IDLE);
    assign dat_ready  = (state == SEND);

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)              state_nx = CONVERT;
            CONVERT: if (last_shift)         state_nx = SEND;
            SEND:    if (xfer && last_digit) state_nx = IDLE;
            default:                         state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            idx      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Saturating keeps every nibble <= 9, so the top digit never carries out
                        if (valor > MAX_W) begin
                            bin      <= MAX_W;
                            overflow <= 1'b1;
                        end else begin
                            bin      <= valor;
                            overflow <= 1'b0;
                        end
                        bcd <= '0;
                        cnt <= CW'(WIDTH);
                        idx <= '0;
                    end
                end
                CONVERT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    cnt        <= cnt - CW'(1);
                end
                SEND: begin
                    if (dat_ack) begin
                        if (last_digit) begin
                            idx  <= '0;
                            done <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // sig_digit[i]: some digit at position i or above is nonzero
    logic [DIGITS-1:0] sig_digit;
    logic              any_nz;

    always_comb begin
        sig_digit = '0;
        any_nz    = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nz       = any_nz | (bcd[4*i +: 4] != 4'd0);
            sig_digit[i] = any_nz;
        end
    end

    always_comb begin
        dato = 4'h0;
        if (state == SEND) begin
            if ((idx != '0) && !sig_digit[idx]) dato = 4'hF;
            else                                dato = bcd[{idx, 2'b00} +: 4];
        end
    end
`else
    always_comb begin
        dato = 4'h0;
        if (state == SEND) dato = bcd[{idx, 2'b00} +: 4];
    end
`endif

endmodule

// File: tb/tb_module_result_emitter.sv
// Directed bench for module_result_emitter with a digit scoreboard queue.
module tb_module_result_emitter;

    localparam int WIDTH  = 14;
    localparam int DIGITS = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] valor = '0;
    logic             start = 1'b0;
    logic             dat_ack = 1'b0;
    logic             busy, dat_ready, done, overflow;
    logic [3:0]       dato;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [3:0] exp_q[$];
    logic       exp_ovf  = 1'b0;

    always #5 clk = ~clk;

    module_result_emitter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .valor(valor), .start(start), .busy(busy),
        .dato(dato), .dat_ready(dat_ready), .dat_ack(dat_ack), .done(done),
        .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void push_exp(input int v);
        int sat;
        int p;
        logic [3:0] d;
        sat     = (v > 9999) ? 9999 : v;
        exp_ovf = (v > 9999);
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = 4'((sat / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && sat < p) d = 4'hF;
`endif
            exp_q.push_back(d);
            p = p * 10;
        end
    endfunction

    task automatic do_start(input int v);
        @(negedge clk);
        valor = WIDTH'(v);
        start = 1'b1;
        push_exp(v);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("ready_low_convert", dat_ready, 0);
        chk("done_low_convert", done, 0);
    endtask

    // hold: negedges ack stays low per digit; lat: expected idle negedges before ready (-1 skips)
    task automatic run_xfer(input int hold, input int lat);
        int got = 0;
        int wait_n = 0;
        int held = 0;
        int cyc = 0;
        dat_ack = (hold == 0);
        while (got < DIGITS && cyc < 300) begin
            if (dat_ready) begin
                if (lat >= 0) begin
                    chk("latency", wait_n, lat);
                    lat = -1;
                end
                if (held < hold) begin
                    dat_ack = 1'b0;
                    chk("dato_stable", dato, exp_q[0]);
                    held++;
                end else begin
                    dat_ack = 1'b1;
                    chk("dato", dato, exp_q.pop_front());
                    got++;
                    held = 0;
                end
            end else begin
                wait_n++;
                if (hold > 0) dat_ack = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("digits_received", got, DIGITS);
        dat_ack = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 0);
        chk("overflow", overflow, exp_ovf);
        chk("scoreboard_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("ready_idle", dat_ready, 0);
    endtask

    initial begin
        int c;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", dat_ready, 0);
        chk("rst_dato", dato, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b1;

        do_start(9801);
        run_xfer(0, 14);

        do_start(0);
        run_xfer(0, 14);

        do_start(12000);
        run_xfer(0, 14);
        do_start(42);
        run_xfer(0, 14);

        do_start(56);
        run_xfer(5, 14);

        // second start during CONVERT must be dropped
        do_start(3);
        @(negedge clk);
        valor = WIDTH'(77);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        valor = '0;
        run_xfer(0, -1);

        // reset in the middle of SEND
        do_start(15000);
        dat_ack = 1'b1;
        c = 0;
        while (!dat_ready && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("pre_reset_ready", dat_ready, 1);
        chk("pre_reset_dato", dato, exp_q.pop_front());
        chk("pre_reset_ovf", overflow, 1);
        @(negedge clk);
        chk("second_digit", dato, exp_q[0]);
        #2 rst = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_ready", dat_ready, 0);
        chk("async_dato", dato, 0);
        chk("async_done", done, 0);
        chk("async_ovf", overflow, 0);
        exp_q.delete();
        dat_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_done", done, 0);
        chk("post_reset_busy", busy, 0);
        do_start(4321);
        run_xfer(0, 14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
